// File: rtl/hazard_pkg.sv
// Shared types and constants for the hazard/forwarding controller.
package hazard_pkg;

    // Multi-cycle multiply/divide tracking states.
    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_BUSY = 2'd1,
        MD_DONE = 2'd2
    } md_state_e;

    // Width of the saturating stall-cycle counter.
    localparam int STALL_CW = 32;

    // Forward-select codes; stage k is encoded as k.
    localparam int FWD_RF     = 0;
    localparam int FWD_EX_MEM = 1;
    localparam int FWD_MEM_WB = 2;

    // Forward-select width for a given number of forwarding stages.
    function automatic int fw_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/hazard_forward_ctrl_if.sv
// Pipeline-side signal bundle of the hazard/forwarding controller.
// slave: the controller; master: the pipeline that drives it.
interface hazard_forward_ctrl_if
    import hazard_pkg::*;
#(
    parameter int REG_AW    = 5,
    parameter int FWD_DEPTH = 2
);
    localparam int FW = fw_width(FWD_DEPTH);

    logic [REG_AW-1:0]           id_rs1;
    logic [REG_AW-1:0]           id_rs2;
    logic                        ex_valid;
    logic [REG_AW-1:0]           ex_rs1;
    logic [REG_AW-1:0]           ex_rs2;
    logic [REG_AW-1:0]           ex_rd;
    logic                        ex_regwrite;
    logic                        ex_is_load;
    logic                        ex_is_md;
    logic [FWD_DEPTH*REG_AW-1:0] fwd_rd;
    logic [FWD_DEPTH-1:0]        fwd_regwrite;

    logic [FW-1:0]               forward_a;
    logic [FW-1:0]               forward_b;
    logic                        stall;
    logic                        bubble;
    logic                        ex_hold;
    logic [STALL_CW-1:0]         stall_cycles;

    modport master (
        output id_rs1, id_rs2, ex_valid, ex_rs1, ex_rs2, ex_rd,
               ex_regwrite, ex_is_load, ex_is_md, fwd_rd, fwd_regwrite,
        input  forward_a, forward_b, stall, bubble, ex_hold, stall_cycles
    );

    modport slave (
        input  id_rs1, id_rs2, ex_valid, ex_rs1, ex_rs2, ex_rd,
               ex_regwrite, ex_is_load, ex_is_md, fwd_rd, fwd_regwrite,
        output forward_a, forward_b, stall, bubble, ex_hold, stall_cycles
    );

endinterface

// File: rtl/fwd_select.sv
// Priority encoder choosing the nearest downstream stage that writes the
// requested source register. x0 is never forwarded.
module fwd_select
    import hazard_pkg::*;
#(
    parameter int REG_AW    = 5,
    parameter int FWD_DEPTH = 2,
    parameter int FW        = fw_width(FWD_DEPTH)
) (
    input  logic [REG_AW-1:0]           src_i,
    input  logic [FWD_DEPTH*REG_AW-1:0] fwd_rd_i,
    input  logic [FWD_DEPTH-1:0]        fwd_regwrite_i,
    output logic [FW-1:0]               sel_o
);

    // Scan farthest to nearest so the nearest match is the last to write.
    always_comb begin
        sel_o = FW'(FWD_RF);
        for (int k = FWD_DEPTH; k >= 1; k--) begin
            if (fwd_regwrite_i[k-1] && (src_i != '0) &&
                (fwd_rd_i[(k-1)*REG_AW +: REG_AW] == src_i)) begin
                sel_o = FW'(k);
            end
        end
    end

endmodule

// File: rtl/hazard_forward_ctrl.sv
// Hazard and forwarding controller beside the ID/EX stage.
// Optional macro HAZARD_MD_EN: adds the multi-cycle mul/div hold FSM.
//
// state   | meaning
// MD_IDLE | no multi-cycle op in EX; a new md op raises ex_hold at once
// MD_BUSY | md op still computing; cnt counts remaining hold cycles
// MD_DONE | final cycle of the md op in EX; ex_hold low, ex_is_md ignored
module hazard_forward_ctrl
    import hazard_pkg::*;
#(
    parameter int REG_AW    = 5,
    parameter int FWD_DEPTH = 2,
    parameter int MD_LAT    = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    hazard_forward_ctrl_if.slave bus
);

    logic                load_use;
    logic                ex_hold;
    logic                stall;
    logic [STALL_CW-1:0] stall_cycles_q;
    logic [STALL_CW-1:0] stall_cycles_d;

    fwd_select #(.REG_AW(REG_AW), .FWD_DEPTH(FWD_DEPTH)) u_fwd_a (
        .src_i          (bus.ex_rs1),
        .fwd_rd_i       (bus.fwd_rd),
        .fwd_regwrite_i (bus.fwd_regwrite),
        .sel_o          (bus.forward_a)
    );

    fwd_select #(.REG_AW(REG_AW), .FWD_DEPTH(FWD_DEPTH)) u_fwd_b (
        .src_i          (bus.ex_rs2),
        .fwd_rd_i       (bus.fwd_rd),
        .fwd_regwrite_i (bus.fwd_regwrite),
        .sel_o          (bus.forward_b)
    );

    assign load_use = bus.ex_valid & bus.ex_is_load & bus.ex_regwrite &
                      (bus.ex_rd != '0) &
                      ((bus.ex_rd == bus.id_rs1) | (bus.ex_rd == bus.id_rs2));

`ifdef HAZARD_MD_EN
    localparam int CW = $clog2(MD_LAT);

    md_state_e      state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;

    // State and hold-counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= MD_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state and ex_hold; the IDLE cycle counts as the first hold cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ex_hold = 1'b0;
        case (state_q)
            MD_IDLE: begin
                if (bus.ex_valid && bus.ex_is_md) begin
                    ex_hold = 1'b1;
                    if (MD_LAT == 2) begin
                        state_d = MD_DONE;
                    end else begin
                        state_d = MD_BUSY;
                        cnt_d   = CW'(MD_LAT - 2);
                    end
                end
            end
            MD_BUSY: begin
                ex_hold = 1'b1;
                if (cnt_q == CW'(1)) begin
                    state_d = MD_DONE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            MD_DONE: state_d = MD_IDLE;
            default: state_d = MD_IDLE;
        endcase
    end
`else
    logic unused_md;

    assign unused_md = bus.ex_is_md;
    assign ex_hold   = 1'b0;
`endif

    assign stall       = load_use | ex_hold;
    assign bus.stall   = stall;
    assign bus.bubble  = load_use & ~ex_hold;
    assign bus.ex_hold = ex_hold;

    // Saturating count of stalled cycles.
    always_comb begin
        stall_cycles_d = stall_cycles_q;
        if (stall && (stall_cycles_q != '1)) begin
            stall_cycles_d = stall_cycles_q + STALL_CW'(1);
        end
    end

    // Stall counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles_q <= '0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign bus.stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// Bench for hazard_forward_ctrl: directed scenarios plus a randomized run
// against a cycle-age reference model. Expectations follow HAZARD_MD_EN.
`timescale 1ns/1ps
module tb_hazard_forward_ctrl;
    import hazard_pkg::*;

    localparam int AW = 5;
    localparam int DA = 3;
    localparam int LA = 4;
    localparam int DB = 2;
    localparam int LB = 2;

`ifdef HAZARD_MD_EN
    localparam bit MD_EN = 1'b1;
`else
    localparam bit MD_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    hazard_forward_ctrl_if #(.REG_AW(AW), .FWD_DEPTH(DA)) bus_a ();
    hazard_forward_ctrl_if #(.REG_AW(AW), .FWD_DEPTH(DB)) bus_b ();

    hazard_forward_ctrl #(.REG_AW(AW), .FWD_DEPTH(DA), .MD_LAT(LA)) u_dut (
        .clk(clk), .rst_n(rst_n), .bus(bus_a)
    );

    hazard_forward_ctrl #(.REG_AW(AW), .FWD_DEPTH(DB), .MD_LAT(LB)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .bus(bus_b)
    );

    int n_pass  = 0;
    int n_total = 0;

    // Stimulus for instance A.
    int id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd;
    bit ex_valid, ex_regwrite, ex_is_load, ex_is_md;
    int st_rd[DA];
    bit st_we[DA];

    // Reference state: cycles elapsed in the current md op (-1 = none).
    int md_age = -1;
    longint unsigned exp_cnt = 0;

    function automatic int cur_age();
        if (!MD_EN) return -1;
        if (md_age >= 0) return md_age;
        return (ex_valid && ex_is_md) ? 0 : -1;
    endfunction

    function automatic bit ref_hold();
        int a;
        a = cur_age();
        return (a >= 0) && (a <= LA - 2);
    endfunction

    function automatic bit ref_lu();
        return ex_valid && ex_is_load && ex_regwrite && (ex_rd != 0) &&
               ((ex_rd == id_rs1) || (ex_rd == id_rs2));
    endfunction

    function automatic int ref_fwd(input int src);
        if (src == 0) return 0;
        for (int k = 1; k <= DA; k++)
            if (st_we[k-1] && (st_rd[k-1] == src)) return k;
        return 0;
    endfunction

    task automatic drive();
        bus_a.id_rs1      = AW'(id_rs1);
        bus_a.id_rs2      = AW'(id_rs2);
        bus_a.ex_valid    = ex_valid;
        bus_a.ex_rs1      = AW'(ex_rs1);
        bus_a.ex_rs2      = AW'(ex_rs2);
        bus_a.ex_rd       = AW'(ex_rd);
        bus_a.ex_regwrite = ex_regwrite;
        bus_a.ex_is_load  = ex_is_load;
        bus_a.ex_is_md    = ex_is_md;
        for (int k = 0; k < DA; k++) begin
            bus_a.fwd_rd[k*AW +: AW] = AW'(st_rd[k]);
            bus_a.fwd_regwrite[k]    = st_we[k];
        end
    endtask

    task automatic clear_inputs();
        id_rs1 = 0; id_rs2 = 0; ex_rs1 = 0; ex_rs2 = 0; ex_rd = 0;
        ex_valid = 0; ex_regwrite = 0; ex_is_load = 0; ex_is_md = 0;
        for (int k = 0; k < DA; k++) begin
            st_rd[k] = 0;
            st_we[k] = 0;
        end
        drive();
        bus_b.id_rs1 = '0; bus_b.id_rs2 = '0; bus_b.ex_valid = 1'b0;
        bus_b.ex_rs1 = '0; bus_b.ex_rs2 = '0; bus_b.ex_rd = '0;
        bus_b.ex_regwrite = 1'b0; bus_b.ex_is_load = 1'b0; bus_b.ex_is_md = 1'b0;
        bus_b.fwd_rd = '0; bus_b.fwd_regwrite = '0;
    endtask

    // Advance one clock and move the reference model with it.
    task automatic tick();
        int a;
        bit s;
        a = cur_age();
        s = ref_hold() || ref_lu();
        @(posedge clk);
        if (s && (exp_cnt != 64'hFFFF_FFFF)) exp_cnt++;
        md_age = (a >= 0 && a < LA - 1) ? a + 1 : -1;
        #1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        clear_inputs();
        md_age  = -1;
        exp_cnt = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_reset();
        apply_reset();
        #1;
        n_total++; if (bus_a.forward_a !== 0) $display("FAIL reset_forward_a: got %0d want 0", bus_a.forward_a); else n_pass++;
        n_total++; if (bus_a.forward_b !== 0) $display("FAIL reset_forward_b: got %0d want 0", bus_a.forward_b); else n_pass++;
        n_total++; if (bus_a.stall !== 1'b0) $display("FAIL reset_stall: got %b want 0", bus_a.stall); else n_pass++;
        n_total++; if (bus_a.bubble !== 1'b0) $display("FAIL reset_bubble: got %b want 0", bus_a.bubble); else n_pass++;
        n_total++; if (bus_a.ex_hold !== 1'b0) $display("FAIL reset_ex_hold: got %b want 0", bus_a.ex_hold); else n_pass++;
        n_total++; if (bus_a.stall_cycles !== 32'd0) $display("FAIL reset_stall_cycles: got %0d want 0", bus_a.stall_cycles); else n_pass++;
        n_total++; if (bus_b.stall_cycles !== 32'd0) $display("FAIL reset_b_stall_cycles: got %0d want 0", bus_b.stall_cycles); else n_pass++;
    endtask

    task automatic test_forwarding();
        clear_inputs();
        ex_rs1 = 5;
        st_rd = '{9, 5, 5};
        st_we = '{1, 1, 1};
        drive(); #1;
        n_total++; if (bus_a.forward_a !== 2) $display("FAIL fwd_stage2_wins: got %0d want 2", bus_a.forward_a); else n_pass++;
        st_rd[0] = 5; st_we[0] = 0;
        drive(); #1;
        n_total++; if (bus_a.forward_a !== 2) $display("FAIL fwd_stage1_nowrite: got %0d want 2", bus_a.forward_a); else n_pass++;
        st_we[0] = 1;
        drive(); #1;
        n_total++; if (bus_a.forward_a !== 1) $display("FAIL fwd_nearest: got %0d want 1", bus_a.forward_a); else n_pass++;
        ex_rs2 = 5; st_we = '{0, 0, 1};
        drive(); #1;
        n_total++; if (bus_a.forward_b !== 3) $display("FAIL fwd_stage3: got %0d want 3", bus_a.forward_b); else n_pass++;
        ex_rs1 = 0; ex_rs2 = 0;
        st_rd = '{0, 0, 0};
        st_we = '{1, 1, 1};
        drive(); #1;
        n_total++; if (bus_a.forward_b !== 0) $display("FAIL fwd_x0_b: got %0d want 0", bus_a.forward_b); else n_pass++;
        n_total++; if (bus_a.forward_a !== 0) $display("FAIL fwd_x0_a: got %0d want 0", bus_a.forward_a); else n_pass++;
        clear_inputs();
    endtask

    task automatic test_load_use();
        apply_reset();
        ex_valid = 1; ex_is_load = 1; ex_regwrite = 1; ex_rd = 7; id_rs1 = 3; id_rs2 = 7;
        drive(); #1;
        n_total++; if (bus_a.stall !== 1'b1) $display("FAIL lu_stall: got %b want 1", bus_a.stall); else n_pass++;
        n_total++; if (bus_a.bubble !== 1'b1) $display("FAIL lu_bubble: got %b want 1", bus_a.bubble); else n_pass++;
        n_total++; if (bus_a.stall_cycles !== 32'd0) $display("FAIL lu_cnt_before: got %0d want 0", bus_a.stall_cycles); else n_pass++;
        tick();
        clear_inputs(); #1;
        n_total++; if (bus_a.stall_cycles !== 32'd1) $display("FAIL lu_cnt_after: got %0d want 1", bus_a.stall_cycles); else n_pass++;
        n_total++; if (bus_a.stall !== 1'b0) $display("FAIL lu_cleared: got %b want 0", bus_a.stall); else n_pass++;
        ex_valid = 1; ex_is_load = 1; ex_regwrite = 1; ex_rd = 0; id_rs1 = 0; id_rs2 = 0;
        drive(); #1;
        n_total++; if (bus_a.stall !== 1'b0) $display("FAIL lu_rd0_stall: got %b want 0", bus_a.stall); else n_pass++;
        n_total++; if (bus_a.bubble !== 1'b0) $display("FAIL lu_rd0_bubble: got %b want 0", bus_a.bubble); else n_pass++;
        tick();
        n_total++; if (bus_a.stall_cycles !== 32'd1) $display("FAIL lu_rd0_cnt: got %0d want 1", bus_a.stall_cycles); else n_pass++;
        clear_inputs();
    endtask

    task automatic test_md_single();
        bit exp_h;
        apply_reset();
        ex_valid = 1; ex_is_md = 1; ex_rs1 = 4; st_rd[0] = 4; st_we[0] = 1;
        drive();
        for (int i = 0; i < 6; i++) begin
            if (i == 4) begin ex_valid = 0; ex_is_md = 0; drive(); end
            #1;
            exp_h = MD_EN && (i < 3);
            n_total++; if (bus_a.ex_hold !== exp_h) $display("FAIL md_hold_c%0d: got %b want %b", i, bus_a.ex_hold, exp_h); else n_pass++;
            n_total++; if (bus_a.stall !== exp_h) $display("FAIL md_stall_c%0d: got %b want %b", i, bus_a.stall, exp_h); else n_pass++;
            n_total++; if (bus_a.forward_a !== 1) $display("FAIL md_fwd_c%0d: got %0d want 1", i, bus_a.forward_a); else n_pass++;
            tick();
        end
        n_total++; if (bus_a.stall_cycles !== (MD_EN ? 32'd3 : 32'd0)) $display("FAIL md_cnt: got %0d want %0d", bus_a.stall_cycles, MD_EN ? 3 : 0); else n_pass++;
        clear_inputs();
    endtask

    task automatic test_back_to_back();
        bit exp_h;
        apply_reset();
        ex_valid = 1; ex_is_md = 1;
        drive();
        for (int i = 0; i < 10; i++) begin
            if (i == 8) begin ex_valid = 0; ex_is_md = 0; drive(); end
            #1;
            exp_h = MD_EN && (i < 8) && ((i % 4) != 3);
            n_total++; if (bus_a.ex_hold !== exp_h) $display("FAIL b2b_hold_c%0d: got %b want %b", i, bus_a.ex_hold, exp_h); else n_pass++;
            tick();
        end
        n_total++; if (bus_a.stall_cycles !== (MD_EN ? 32'd6 : 32'd0)) $display("FAIL b2b_cnt: got %0d want %0d", bus_a.stall_cycles, MD_EN ? 6 : 0); else n_pass++;
        clear_inputs();
    endtask

    task automatic test_priority();
        bit exp_h;
        apply_reset();
        ex_valid = 1; ex_is_md = 1; ex_is_load = 1; ex_regwrite = 1; ex_rd = 7; id_rs1 = 7;
        drive();
        for (int i = 0; i < 4; i++) begin
            #1;
            exp_h = MD_EN && (i < 3);
            n_total++; if (bus_a.stall !== 1'b1) $display("FAIL prio_stall_c%0d: got %b want 1", i, bus_a.stall); else n_pass++;
            n_total++; if (bus_a.bubble !== !exp_h) $display("FAIL prio_bubble_c%0d: got %b want %b", i, bus_a.bubble, !exp_h); else n_pass++;
            tick();
        end
        clear_inputs();
    endtask

    task automatic test_reset_mid_op();
        bit exp_h;
        apply_reset();
        ex_valid = 1; ex_is_md = 1;
        drive();
        tick(); tick();
        #1;
        n_total++; if (bus_a.ex_hold !== MD_EN) $display("FAIL rst_mid_pre_hold: got %b want %b", bus_a.ex_hold, MD_EN); else n_pass++;
        rst_n = 1'b0;
        clear_inputs();
        md_age = -1; exp_cnt = 0;
        #1;
        n_total++; if (bus_a.ex_hold !== 1'b0) $display("FAIL rst_mid_hold: got %b want 0", bus_a.ex_hold); else n_pass++;
        n_total++; if (bus_a.stall_cycles !== 32'd0) $display("FAIL rst_mid_cnt: got %0d want 0", bus_a.stall_cycles); else n_pass++;
        @(posedge clk);
        #1 rst_n = 1'b1;
        ex_valid = 1; ex_is_md = 1;
        drive();
        for (int i = 0; i < 5; i++) begin
            if (i == 4) begin ex_valid = 0; ex_is_md = 0; drive(); end
            #1;
            exp_h = MD_EN && (i < 3);
            n_total++; if (bus_a.ex_hold !== exp_h) $display("FAIL rst_new_hold_c%0d: got %b want %b", i, bus_a.ex_hold, exp_h); else n_pass++;
            tick();
        end
        n_total++; if (bus_a.stall_cycles !== (MD_EN ? 32'd3 : 32'd0)) $display("FAIL rst_new_cnt: got %0d want %0d", bus_a.stall_cycles, MD_EN ? 3 : 0); else n_pass++;
        clear_inputs();
    endtask

    task automatic test_md_lat2();
        apply_reset();
        bus_b.ex_valid = 1'b1; bus_b.ex_is_md = 1'b1;
        #1;
        n_total++; if (bus_b.ex_hold !== MD_EN) $display("FAIL lat2_hold0: got %b want %b", bus_b.ex_hold, MD_EN); else n_pass++;
        @(posedge clk); #1;
        n_total++; if (bus_b.ex_hold !== 1'b0) $display("FAIL lat2_done: got %b want 0", bus_b.ex_hold); else n_pass++;
        bus_b.ex_valid = 1'b0; bus_b.ex_is_md = 1'b0;
        @(posedge clk); #1;
        n_total++; if (bus_b.ex_hold !== 1'b0) $display("FAIL lat2_idle: got %b want 0", bus_b.ex_hold); else n_pass++;
        n_total++; if (bus_b.stall_cycles !== (MD_EN ? 32'd1 : 32'd0)) $display("FAIL lat2_cnt: got %0d want %0d", bus_b.stall_cycles, MD_EN ? 1 : 0); else n_pass++;
        clear_inputs();
    endtask

    task automatic test_random();
        bit h, lu;
        int fa, fb;
        apply_reset();
        for (int c = 0; c < 300; c++) begin
            id_rs1 = $urandom_range(0, 7); id_rs2 = $urandom_range(0, 7);
            ex_rs1 = $urandom_range(0, 7); ex_rs2 = $urandom_range(0, 7);
            ex_rd  = $urandom_range(0, 7);
            ex_valid    = ($urandom_range(0, 3) != 0);
            ex_regwrite = $urandom_range(0, 1);
            ex_is_load  = $urandom_range(0, 1);
            ex_is_md    = ($urandom_range(0, 5) == 0);
            for (int k = 0; k < DA; k++) begin
                st_rd[k] = $urandom_range(0, 7);
                st_we[k] = $urandom_range(0, 1);
            end
            drive(); #1;
            h = ref_hold(); lu = ref_lu();
            fa = ref_fwd(ex_rs1); fb = ref_fwd(ex_rs2);
            n_total++; if (bus_a.forward_a !== fa) $display("FAIL rnd_fwd_a_c%0d: got %0d want %0d", c, bus_a.forward_a, fa); else n_pass++;
            n_total++; if (bus_a.forward_b !== fb) $display("FAIL rnd_fwd_b_c%0d: got %0d want %0d", c, bus_a.forward_b, fb); else n_pass++;
            n_total++; if (bus_a.ex_hold !== h) $display("FAIL rnd_hold_c%0d: got %b want %b", c, bus_a.ex_hold, h); else n_pass++;
            n_total++; if (bus_a.stall !== (h | lu)) $display("FAIL rnd_stall_c%0d: got %b want %b", c, bus_a.stall, h | lu); else n_pass++;
            n_total++; if (bus_a.bubble !== (lu & ~h)) $display("FAIL rnd_bubble_c%0d: got %b want %b", c, bus_a.bubble, lu & ~h); else n_pass++;
            tick();
            n_total++; if (bus_a.stall_cycles !== 32'(exp_cnt)) $display("FAIL rnd_cnt_c%0d: got %0d want %0d", c, bus_a.stall_cycles, exp_cnt); else n_pass++;
        end
        clear_inputs();
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_forwarding();
        test_load_use();
        test_md_single();
        test_back_to_back();
        test_priority();
        test_reset_mid_op();
        test_md_lat2();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
